// File: rtl/fixed_point_pkg.sv
// Shared definitions for the fixed-point arithmetic blocks: divider FSM states
// and saturation limits for W-bit two's complement results.
package fixed_point_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_FIX  = 2'd2
    } div_state_e;

    // Largest positive W-bit two's complement value (0x7F..F), w in 1..64.
    function automatic logic [63:0] sat_max(input int w);
        return (64'd1 << (w - 1)) - 64'd1;
    endfunction

    // Bit pattern of the most negative W-bit value (0x80..0); also the largest
    // magnitude a negative result may have.
    function automatic logic [63:0] sat_min(input int w);
        return 64'd1 << (w - 1);
    endfunction

endpackage

// File: rtl/fixed_point_sat.sv
// Applies a sign to an unsigned magnitude and saturates it into a W-bit two's
// complement value. Purely combinational; MW and W must each be at most 63.
module fixed_point_sat
    import fixed_point_pkg::*;
#(
    parameter int MW = 18,
    parameter int W  = 16
) (
    input  logic [MW-1:0] mag,
    input  logic          neg,
    output logic [W-1:0]  value,
    output logic          ovf
);

    localparam int CW = ((MW > W) ? MW : W) + 1;

    logic [CW-1:0] mag_ext_s;
    logic [CW-1:0] lim_pos_s;
    logic [CW-1:0] lim_neg_s;

    // Compare the full magnitude against the limit for the requested sign.
    always_comb begin
        mag_ext_s = CW'(mag);
        lim_pos_s = CW'(sat_max(W));
        lim_neg_s = CW'(sat_min(W));
        value     = W'(mag_ext_s);
        ovf       = 1'b0;
        if (neg) begin
            if (mag_ext_s > lim_neg_s) begin
                value = W'(lim_neg_s);
                ovf   = 1'b1;
            end else begin
                value = ~W'(mag_ext_s) + W'(1'b1);
                ovf   = 1'b0;
            end
        end else begin
            if (mag_ext_s > lim_pos_s) begin
                value = W'(lim_pos_s);
                ovf   = 1'b1;
            end else begin
                value = W'(mag_ext_s);
                ovf   = 1'b0;
            end
        end
    end

endmodule

// File: rtl/fixed_point_div.sv
// Signed fixed-point divider, data_out = in_1 / in_2, using an iterative
// restoring algorithm that yields one quotient bit per clock at fixed latency.
module fixed_point_div
    import fixed_point_pkg::*;
#(
    parameter int WI_1 = 3,
    parameter int WF_1 = 5,
    parameter int WI_2 = 3,
    parameter int WF_2 = 5,
    parameter int WI_O = WI_1 + WF_2,
    parameter int WF_O = WF_1 + WF_2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WI_1+WF_1-1:0]   in_1,
    input  logic [WI_2+WF_2-1:0]   in_2,
    output logic                   ready,
    output logic                   valid,
    output logic [WI_O+WF_O-1:0]   data_out,
    output logic                   ovf,
    output logic                   div_zero
);

    localparam int N1   = WI_1 + WF_1;
    localparam int N2   = WI_2 + WF_2;
    localparam int SH   = WF_2 + WF_O - WF_1;
    localparam int NW   = N1 + SH;
    localparam int W_O  = WI_O + WF_O;
    localparam int CNTW = $clog2(NW + 1);

    generate
        if (SH < 0) begin : g_bad_format
            $error("fixed_point_div: WF_2 + WF_O must be >= WF_1");
        end
    endgenerate

    div_state_e     state_r, state_s;
    logic [CNTW-1:0] cnt_r;
    logic [NW-1:0]  num_r;
    logic [NW-1:0]  quo_r;
    logic [N2:0]    div_r;
    logic [N2:0]    rem_r;
    logic           sign_r;
    logic           dz_r;
    logic           in1_neg_r;
    logic           in1_nz_r;

    logic [N1:0]    mag1_s;
    logic [N2:0]    mag2_s;
    logic [NW-1:0]  num_init_s;
    logic [N2+1:0]  rem_sh_s;
    logic [N2+1:0]  rem_sub_s;
    logic [W_O-1:0] sat_val_s;
    logic           sat_ovf_s;
    logic [W_O-1:0] res_s;
    logic           res_ovf_s;

    // Magnitudes are one bit wider than the operands so -2^(n-1) stays exact.
    always_comb begin
        mag1_s     = in_1[N1-1] ? (~{in_1[N1-1], in_1} + (N1+1)'(1'b1)) : {1'b0, in_1};
        mag2_s     = in_2[N2-1] ? (~{in_2[N2-1], in_2} + (N2+1)'(1'b1)) : {1'b0, in_2};
        num_init_s = NW'(mag1_s) << SH;
        rem_sh_s   = {rem_r, num_r[NW-1]};
        rem_sub_s  = rem_sh_s - {1'b0, div_r};
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_CALC;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_CALC: begin
                if (cnt_r == CNTW'(NW - 1)) begin
                    state_s = ST_FIX;
                end else begin
                    state_s = ST_CALC;
                end
            end
            ST_FIX:  state_s = ST_IDLE;
            default: state_s = ST_IDLE;
        endcase
    end

    fixed_point_sat #(
        .MW (NW),
        .W  (W_O)
    ) u_sat (
        .mag   (quo_r),
        .neg   (sign_r),
        .value (sat_val_s),
        .ovf   (sat_ovf_s)
    );

    // Divide by zero forces the saturation limit matching the dividend's sign.
    always_comb begin
        res_s     = sat_val_s;
        res_ovf_s = sat_ovf_s;
        if (dz_r) begin
            if (in1_neg_r) begin
                res_s     = W_O'(sat_min(W_O));
                res_ovf_s = 1'b1;
            end else if (in1_nz_r) begin
                res_s     = W_O'(sat_max(W_O));
                res_ovf_s = 1'b1;
            end else begin
                res_s     = {W_O{1'b0}};
                res_ovf_s = 1'b0;
            end
        end else begin
            res_s     = sat_val_s;
            res_ovf_s = sat_ovf_s;
        end
    end

    // State register, iteration datapath and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= ST_IDLE;
            cnt_r     <= {CNTW{1'b0}};
            num_r     <= {NW{1'b0}};
            quo_r     <= {NW{1'b0}};
            div_r     <= {(N2+1){1'b0}};
            rem_r     <= {(N2+1){1'b0}};
            sign_r    <= 1'b0;
            dz_r      <= 1'b0;
            in1_neg_r <= 1'b0;
            in1_nz_r  <= 1'b0;
            ready     <= 1'b1;
            valid     <= 1'b0;
            data_out  <= {W_O{1'b0}};
            ovf       <= 1'b0;
            div_zero  <= 1'b0;
        end else begin
            state_r <= state_s;
            ready   <= (state_s == ST_IDLE);
            valid   <= (state_r == ST_FIX);
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        cnt_r     <= {CNTW{1'b0}};
                        num_r     <= num_init_s;
                        quo_r     <= {NW{1'b0}};
                        div_r     <= mag2_s;
                        rem_r     <= {(N2+1){1'b0}};
                        sign_r    <= in_1[N1-1] ^ in_2[N2-1];
                        dz_r      <= (in_2 == {N2{1'b0}});
                        in1_neg_r <= in_1[N1-1];
                        in1_nz_r  <= (in_1 != {N1{1'b0}});
                    end
                end
                ST_CALC: begin
                    cnt_r <= cnt_r + CNTW'(1'b1);
                    num_r <= num_r << 1;
                    if (rem_sh_s >= {1'b0, div_r}) begin
                        rem_r <= (N2+1)'(rem_sub_s);
                        quo_r <= {quo_r[NW-2:0], 1'b1};
                    end else begin
                        rem_r <= (N2+1)'(rem_sh_s);
                        quo_r <= {quo_r[NW-2:0], 1'b0};
                    end
                end
                ST_FIX: begin
                    data_out <= res_s;
                    ovf      <= res_ovf_s;
                    div_zero <= dz_r;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
